// File: rtl/seg7_display_reader.sv
// Receive-side reader for a three-digit 7-segment bus (hundreds, tens, units).
// Waits for a stable segment triple, decodes it to BCD, converts to binary with
// a multiply-by-10 accumulator and reports the result over valid/ready.
module seg7_display_reader #(
  parameter int unsigned STABLE_CYCLES = 4  // legal 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_h,
  input  logic [6:0]  seg_t,
  input  logic [6:0]  seg_u,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [9:0]  bin_value,
  output logic [11:0] bcd_value,
  output logic        err_invalid,
  output logic [2:0]  err_digit
);

  typedef enum logic [1:0] {StIdle, StConv, StValid} state_e;

  localparam logic [3:0] StableMax = 4'(STABLE_CYCLES);

  // Returns {invalid, digit}; an invalid pattern decodes to 4'hF.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1111110: r = 5'h00;
      7'b0110000: r = 5'h01;
      7'b1101101: r = 5'h02;
      7'b1111001: r = 5'h03;
      7'b0110011: r = 5'h04;
      7'b1011011: r = 5'h05;
      7'b1011111: r = 5'h06;
      7'b1110000: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1111011: r = 5'h09;
      default:    r = {1'b1, 4'hF};
    endcase
    return r;
  endfunction

  state_e      state_q;
  logic [20:0] seg_q;
  logic [3:0]  run_q, run_d;
  logic [20:0] last_rep_q;
  logic        first_q;
  logic [20:0] lat_q;
  logic [11:0] dig_q;
  logic [2:0]  err_lat_q;
  logic [9:0]  acc_q, acc_d;
  logic [1:0]  cnt_q;

  logic [20:0] seg_in;
  logic [4:0]  dec_h, dec_t, dec_u;
  logic        capture;
  logic [3:0]  cur_digit;
  logic [3:0]  addend;

  assign seg_in = {seg_h, seg_t, seg_u};
  assign dec_h  = seg_decode(seg_q[20:14]);
  assign dec_t  = seg_decode(seg_q[13:7]);
  assign dec_u  = seg_decode(seg_q[6:0]);

  // Stability run counter (saturating) and capture decision on the registered triple.
  always_comb begin
    run_d = 4'd1;
    if (seg_in == seg_q) begin
      run_d = (run_q == StableMax) ? run_q : run_q + 4'd1;
    end
    capture = (run_q == StableMax) && (first_q || (seg_q != last_rep_q));
  end

  // Select the digit for this conversion step; an invalid digit adds nothing.
  always_comb begin
    case (cnt_q)
      2'd0:    cur_digit = dig_q[11:8];
      2'd1:    cur_digit = dig_q[7:4];
      default: cur_digit = dig_q[3:0];
    endcase
    addend = (cur_digit > 4'd9) ? 4'd0 : cur_digit;
    acc_d  = {acc_q[6:0], 3'b000} + {acc_q[8:0], 1'b0} + {6'd0, addend};
  end

  // Input sampling plus the capture/convert/report FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      seg_q       <= '0;
      run_q       <= '0;
      last_rep_q  <= '0;
      first_q     <= 1'b1;
      lat_q       <= '0;
      dig_q       <= '0;
      err_lat_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid   <= 1'b0;
      bin_value   <= '0;
      bcd_value   <= '0;
      err_invalid <= 1'b0;
      err_digit   <= '0;
    end else begin
      seg_q <= seg_in;
      run_q <= run_d;
      case (state_q)
        StIdle: begin
          if (capture) begin
            lat_q     <= seg_q;
            dig_q     <= {dec_h[3:0], dec_t[3:0], dec_u[3:0]};
            err_lat_q <= {dec_h[4], dec_t[4], dec_u[4]};
            acc_q     <= '0;
            cnt_q     <= '0;
            state_q   <= StConv;
          end
        end
        StConv: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd2) begin
            state_q     <= StValid;
            out_valid   <= 1'b1;
            bin_value   <= (|err_lat_q) ? 10'd0 : acc_d;
            bcd_value   <= dig_q;
            err_invalid <= |err_lat_q;
            err_digit   <= err_lat_q;
          end
        end
        StValid: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            last_rep_q <= lat_q;
            first_q    <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_display_reader.sv
// Directed bench for seg7_display_reader with hand-computed expectations.
module tb_seg7_display_reader;

  logic        clk;
  logic        reset;
  logic [6:0]  seg_h, seg_t, seg_u;
  logic        out_ready;
  logic        out_valid;
  logic [9:0]  bin_value;
  logic [11:0] bcd_value;
  logic        err_invalid;
  logic [2:0]  err_digit;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] seg_lut [10];

  seg7_display_reader #(.STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .seg_h      (seg_h),
    .seg_t      (seg_t),
    .seg_u      (seg_u),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .bin_value  (bin_value),
    .bcd_value  (bcd_value),
    .err_invalid(err_invalid),
    .err_digit  (err_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digits(input int h, input int t, input int u);
    seg_h = seg_lut[h];
    seg_t = seg_lut[t];
    seg_u = seg_lut[u];
  endtask

  // Counts edges until out_valid rises, bounded by max_edges.
  task automatic wait_valid(input int max_edges, output int edges);
    edges = 0;
    while (!out_valid && edges < max_edges) begin
      tick();
      edges++;
    end
    if (!out_valid) check_eq("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  // Holds for n edges and returns how many of them showed out_valid high.
  task automatic count_valid(input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (out_valid) hits++;
    end
  endtask

  initial begin
    int e;
    int hits;
    seg_lut[0] = 7'b1111110; seg_lut[1] = 7'b0110000; seg_lut[2] = 7'b1101101;
    seg_lut[3] = 7'b1111001; seg_lut[4] = 7'b0110011; seg_lut[5] = 7'b1011011;
    seg_lut[6] = 7'b1011111; seg_lut[7] = 7'b1110000; seg_lut[8] = 7'b1111111;
    seg_lut[9] = 7'b1111011;

    reset     = 1'b0;
    out_ready = 1'b1;
    set_digits(0, 0, 0);
    repeat (3) tick();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_bin", 32'(bin_value), 32'd0);
    check_eq("rst_bcd", 32'(bcd_value), 32'd0);
    check_eq("rst_err", 32'(err_invalid), 32'd0);
    check_eq("rst_errdig", 32'(err_digit), 32'd0);

    // 1: "000" after release, valid after edge 8, single report.
    reset = 1'b1;
    repeat (7) tick();
    check_eq("t1_not_yet", 32'(out_valid), 32'd0);
    tick();
    check_eq("t1_valid", 32'(out_valid), 32'd1);
    check_eq("t1_bin", 32'(bin_value), 32'd0);
    check_eq("t1_bcd", 32'(bcd_value), 32'h000);
    check_eq("t1_err", 32'(err_invalid), 32'd0);
    tick();
    check_eq("t1_hs_clear", 32'(out_valid), 32'd0);
    count_valid(20, hits);
    check_eq("t1_no_repeat", 32'(hits), 32'd0);

    // 2: "999", no second report during a long hold.
    set_digits(9, 9, 9);
    wait_valid(20, e);
    check_eq("t2_latency", 32'(e), 32'd8);
    check_eq("t2_bin", 32'(bin_value), 32'h3E7);
    check_eq("t2_bcd", 32'(bcd_value), 32'h999);
    tick();
    count_valid(50, hits);
    check_eq("t2_no_repeat", 32'(hits), 32'd0);

    // 3: "123" glitch for 2 edges, then "456".
    out_ready = 1'b0;
    set_digits(1, 2, 3);
    repeat (2) tick();
    set_digits(4, 5, 6);
    wait_valid(20, e);
    check_eq("t3_latency", 32'(e), 32'd8);
    check_eq("t3_bin", 32'(bin_value), 32'h1C8);
    check_eq("t3_bcd", 32'(bcd_value), 32'h456);

    // 4: back-pressure while input moves to "078", then handshake.
    set_digits(0, 7, 8);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("t4_hold_valid", 32'(out_valid), 32'd1);
      check_eq("t4_hold_bin", 32'(bin_value), 32'h1C8);
      check_eq("t4_hold_bcd", 32'(bcd_value), 32'h456);
    end
    out_ready = 1'b1;
    tick();
    check_eq("t4_hs_clear", 32'(out_valid), 32'd0);
    wait_valid(20, e);
    check_eq("t4_latency", 32'(e), 32'd4);
    check_eq("t4_bin", 32'(bin_value), 32'h04E);
    check_eq("t4_bcd", 32'(bcd_value), 32'h078);
    tick();

    // 5: blank tens digit.
    seg_h = seg_lut[5];
    seg_t = 7'b0000000;
    seg_u = seg_lut[5];
    wait_valid(20, e);
    check_eq("t5_latency", 32'(e), 32'd8);
    check_eq("t5_err", 32'(err_invalid), 32'd1);
    check_eq("t5_errdig", 32'(err_digit), 32'b010);
    check_eq("t5_bcd", 32'(bcd_value), 32'h5F5);
    check_eq("t5_bin", 32'(bin_value), 32'd0);
    tick();

    // 6: reset in the middle of converting "321".
    set_digits(3, 2, 1);
    repeat (6) tick();
    check_eq("t6_in_conv", 32'(out_valid), 32'd0);
    reset = 1'b0;
    tick();
    check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
    check_eq("t6_rst_bcd", 32'(bcd_value), 32'd0);
    check_eq("t6_rst_errdig", 32'(err_digit), 32'd0);
    reset = 1'b1;
    wait_valid(20, e);
    check_eq("t6_latency", 32'(e), 32'd8);
    check_eq("t6_bin", 32'(bin_value), 32'h141);
    check_eq("t6_bcd", 32'(bcd_value), 32'h321);
    check_eq("t6_err", 32'(err_invalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
